sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO for buffering data between producer and consumer logic in one clock domain. It generalises the team's fixed 8x16 FIFO in several ways:
- configurable data width and depth;
- circular read/write pointers, so no shift register;
- occupancy count output;
- programmable almost-full and almost-empty thresholds;
- synchronous flush;
- selectable first-word-fall-through (FWFT) or registered read mode.

---
 rtl/sync_fifo_param_if.sv | 30 +++
 rtl/sync_fifo_param.sv | 60 ++++++
 tb/tb_sync_fifo_param.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer bundle for the parametrised FIFO
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);
  logic              en;
  logic              clear;
  logic              push_in;
  logic              pop_in;
  logic [DATA_W-1:0] din;
  logic [AW:0]       af_th;
  logic [AW:0]       ae_th;
  logic [DATA_W-1:0] dout;
  logic [AW:0]       count;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic              almost_empty;
  logic              overrun;
  logic              underrun;
  modport master (
    output en, clear, push_in, pop_in, din, af_th, ae_th,
    input  dout, count, empty, full, almost_full, almost_empty, overrun, underrun
  );
  modport slave (
    input  en, clear, push_in, pop_in, din, af_th, ae_th,
    output dout, count, empty, full, almost_full, almost_empty, overrun, underrun
  );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: circular-pointer FIFO with count, thresholds, flush and FWFT/registered read
module sync_fifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter bit FWFT   = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  sync_fifo_param_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              overrun_q, overrun_d, underrun_q, underrun_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              empty, full, pop_acc, push_acc;
  assign empty    = count_q == '0;
  assign full     = count_q == FULL_CNT;
  assign pop_acc  = bus.en & bus.pop_in & ~empty & ~bus.clear;
  assign push_acc = bus.en & bus.push_in & (~full | pop_acc) & ~bus.clear;
  always_comb begin
    wr_ptr_d   = bus.clear ? '0 : wr_ptr_q + AW'(push_acc);
    rd_ptr_d   = bus.clear ? '0 : rd_ptr_q + AW'(pop_acc);
    count_d    = bus.clear ? '0 : count_q + (AW+1)'(push_acc) - (AW+1)'(pop_acc);
    overrun_d  = bus.en & bus.push_in & ~push_acc & ~bus.clear;
    underrun_d = bus.en & bus.pop_in & empty & ~bus.clear;
    dout_d     = (!FWFT && pop_acc) ? mem[rd_ptr_q] : dout_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      dout_q     <= dout_d;
    end
  end
  // storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr_q] <= bus.din;
  end
  assign bus.dout         = FWFT ? (empty ? '0 : mem[rd_ptr_q]) : dout_q;
  assign bus.count        = count_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_full  = count_q >= bus.af_th;
  assign bus.almost_empty = count_q <= bus.ae_th;
  assign bus.overrun      = overrun_q;
  assign bus.underrun     = underrun_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed checks of an FWFT instance (a) and a registered-read instance (b)
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) a ();
  sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) b ();
  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(1'b0)) u_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a.en = 1; a.clear = 0; a.push_in = 0; a.pop_in = 0; a.din = '0;
    b.en = 1; b.clear = 0; b.push_in = 0; b.pop_in = 0; b.din = '0;
  endtask

  task automatic test_reset();
    idle();
    a.af_th = 5'd12; a.ae_th = 5'd3; b.af_th = 5'd12; b.ae_th = 5'd3;
    rst_n = 0;
    #3;
    vectors++; if (a.count !== 5'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", a.count); end
    vectors++; if (a.empty !== 1'b1 || a.full !== 1'b0) begin miscompares++; $display("FAIL reset_flags got empty=%b full=%b want 1 0", a.empty, a.full); end
    vectors++; if (a.almost_empty !== 1'b1 || a.almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_thr got ae=%b af=%b want 1 0", a.almost_empty, a.almost_full); end
    vectors++; if (a.dout !== 8'h00 || b.dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout got a=%h b=%h want 00 00", a.dout, b.dout); end
    vectors++; if (a.overrun !== 1'b0 || a.underrun !== 1'b0) begin miscompares++; $display("FAIL reset_err got ovr=%b und=%b want 0 0", a.overrun, a.underrun); end
    tick();
    rst_n = 1;
    tick();
    vectors++; if (a.empty !== 1'b1 || a.count !== 5'd0) begin miscompares++; $display("FAIL post_reset got empty=%b count=%0d want 1 0", a.empty, a.count); end
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 16; k++) begin
      a.push_in = 1; a.din = 8'(k);
      tick();
      vectors++; if (a.count !== 5'(k)) begin miscompares++; $display("FAIL fill_count got %0d want %0d", a.count, k); end
      vectors++; if (a.almost_empty !== (k <= 3)) begin miscompares++; $display("FAIL fill_ae at %0d got %b want %b", k, a.almost_empty, k <= 3); end
      vectors++; if (a.almost_full !== (k >= 12)) begin miscompares++; $display("FAIL fill_af at %0d got %b want %b", k, a.almost_full, k >= 12); end
      vectors++; if (a.dout !== 8'h01) begin miscompares++; $display("FAIL fill_head got %h want 01", a.dout); end
    end
    vectors++; if (a.full !== 1'b1 || a.overrun !== 1'b0) begin miscompares++; $display("FAIL full_flag got full=%b ovr=%b want 1 0", a.full, a.overrun); end
    a.din = 8'hEE;
    tick();
    vectors++; if (a.overrun !== 1'b1 || a.count !== 5'd16) begin miscompares++; $display("FAIL overrun got ovr=%b count=%0d want 1 16", a.overrun, a.count); end
    a.push_in = 0;
    tick();
    vectors++; if (a.overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_pulse got %b want 0", a.overrun); end
    a.en = 0; a.push_in = 1;
    tick();
    vectors++; if (a.overrun !== 1'b0 || a.count !== 5'd16 || a.dout !== 8'h01) begin miscompares++; $display("FAIL en_off got ovr=%b count=%0d dout=%h want 0 16 01", a.overrun, a.count, a.dout); end
    a.en = 1; a.push_in = 0; a.af_th = 5'd17;
    #1;
    vectors++; if (a.almost_full !== 1'b0) begin miscompares++; $display("FAIL af_17 got %b want 0", a.almost_full); end
    a.af_th = 5'd12;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      vectors++; if (a.dout !== 8'(i + 1)) begin miscompares++; $display("FAIL drain_data got %h want %h", a.dout, 8'(i + 1)); end
      a.pop_in = 1;
      tick();
      vectors++; if (a.count !== 5'(15 - i)) begin miscompares++; $display("FAIL drain_count got %0d want %0d", a.count, 15 - i); end
    end
    vectors++; if (a.empty !== 1'b1 || a.dout !== 8'h00 || a.underrun !== 1'b0) begin miscompares++; $display("FAIL drain_end got empty=%b dout=%h und=%b want 1 00 0", a.empty, a.dout, a.underrun); end
    tick();
    vectors++; if (a.underrun !== 1'b1) begin miscompares++; $display("FAIL underrun got %b want 1", a.underrun); end
    a.pop_in = 0;
    tick();
    vectors++; if (a.underrun !== 1'b0) begin miscompares++; $display("FAIL underrun_pulse got %b want 0", a.underrun); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      a.push_in = 1; a.din = 8'(8'h20 + i);
      tick();
    end
    a.push_in = 0;
    for (int i = 0; i < 6; i++) begin
      vectors++; if (a.dout !== 8'(8'h20 + i)) begin miscompares++; $display("FAIL wrap_pop got %h want %h", a.dout, 8'(8'h20 + i)); end
      a.pop_in = 1;
      tick();
    end
    for (int j = 0; j < 20; j++) begin
      vectors++; if (a.dout !== 8'(8'h26 + j)) begin miscompares++; $display("FAIL wrap_order got %h want %h", a.dout, 8'(8'h26 + j)); end
      a.push_in = 1; a.pop_in = 1; a.din = 8'(8'h2A + j);
      tick();
      vectors++; if (a.count !== 5'd4) begin miscompares++; $display("FAIL wrap_count got %0d want 4", a.count); end
    end
    a.push_in = 0;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (a.dout !== 8'(8'h3A + i)) begin miscompares++; $display("FAIL wrap_tail got %h want %h", a.dout, 8'(8'h3A + i)); end
      tick();
    end
    a.pop_in = 0;
    vectors++; if (a.empty !== 1'b1) begin miscompares++; $display("FAIL wrap_empty got %b want 1", a.empty); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      a.push_in = 1; a.din = 8'(8'h40 + i);
      tick();
    end
    a.pop_in = 1; a.din = 8'h99;
    tick();
    vectors++; if (a.count !== 5'd16 || a.overrun !== 1'b0 || a.full !== 1'b1) begin miscompares++; $display("FAIL full_pushpop got count=%0d ovr=%b full=%b want 16 0 1", a.count, a.overrun, a.full); end
    vectors++; if (a.dout !== 8'h41) begin miscompares++; $display("FAIL full_pushpop_head got %h want 41", a.dout); end
    a.push_in = 0;
    for (int i = 0; i < 7; i++) tick();
    a.pop_in = 0;
    vectors++; if (a.count !== 5'd9) begin miscompares++; $display("FAIL pre_clear got %0d want 9", a.count); end
    a.clear = 1; a.push_in = 1; a.pop_in = 1;
    tick();
    a.clear = 0; a.push_in = 0; a.pop_in = 0;
    vectors++; if (a.count !== 5'd0 || a.empty !== 1'b1 || a.dout !== 8'h00) begin miscompares++; $display("FAIL clear got count=%0d empty=%b dout=%h want 0 1 00", a.count, a.empty, a.dout); end
    vectors++; if (a.overrun !== 1'b0 || a.underrun !== 1'b0) begin miscompares++; $display("FAIL clear_err got ovr=%b und=%b want 0 0", a.overrun, a.underrun); end
    a.push_in = 1; a.pop_in = 1; a.din = 8'h77;
    tick();
    a.push_in = 0; a.pop_in = 0;
    vectors++; if (a.count !== 5'd1 || a.underrun !== 1'b1 || a.dout !== 8'h77) begin miscompares++; $display("FAIL empty_pushpop got count=%0d und=%b dout=%h want 1 1 77", a.count, a.underrun, a.dout); end
    a.pop_in = 1;
    tick();
    a.pop_in = 0;
    vectors++; if (a.empty !== 1'b1 || a.underrun !== 1'b0) begin miscompares++; $display("FAIL empty_pushpop_end got empty=%b und=%b want 1 0", a.empty, a.underrun); end
  endtask

  task automatic test_fwft0();
    b.push_in = 1; b.din = 8'hA5;
    tick();
    b.push_in = 0;
    vectors++; if (b.count !== 5'd1 || b.dout !== 8'h00) begin miscompares++; $display("FAIL reg_push got count=%0d dout=%h want 1 00", b.count, b.dout); end
    b.pop_in = 1;
    tick();
    b.pop_in = 0;
    vectors++; if (b.dout !== 8'hA5 || b.count !== 5'd0) begin miscompares++; $display("FAIL reg_pop got dout=%h count=%0d want a5 0", b.dout, b.count); end
    tick();
    vectors++; if (b.dout !== 8'hA5) begin miscompares++; $display("FAIL reg_hold got %h want a5", b.dout); end
    b.clear = 1;
    tick();
    b.clear = 0;
    vectors++; if (b.dout !== 8'hA5 || b.empty !== 1'b1) begin miscompares++; $display("FAIL reg_clear got dout=%h empty=%b want a5 1", b.dout, b.empty); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      a.push_in = 1; b.push_in = 1; a.din = 8'(8'h11 + i); b.din = 8'(8'h11 + i);
      tick();
    end
    b.push_in = 0; b.pop_in = 1;
    tick();
    b.pop_in = 0;
    vectors++; if (a.count !== 5'd4 || b.dout !== 8'h11) begin miscompares++; $display("FAIL pre_rst got a.count=%0d b.dout=%h want 4 11", a.count, b.dout); end
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    vectors++; if (a.count !== 5'd0 || a.empty !== 1'b1 || a.dout !== 8'h00) begin miscompares++; $display("FAIL async_rst_a got count=%0d empty=%b dout=%h want 0 1 00", a.count, a.empty, a.dout); end
    vectors++; if (b.count !== 5'd0 || b.empty !== 1'b1 || b.dout !== 8'h00) begin miscompares++; $display("FAIL async_rst_b got count=%0d empty=%b dout=%h want 0 1 00", b.count, b.empty, b.dout); end
    idle();
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_back_to_back();
    test_fwft0();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
